// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator.
// A prescaler produces a count tick every CLK_DIV clocks. A period counter
// runs in edge-aligned (saw) or center-aligned (triangle) mode. Duty writes
// land in shadow registers and only take effect at a period start, so an
// output never sees a torn period.
// Optional build macro PWM_RAMP_EN: when defined, each period start moves the
// active duty at most one LSB toward the shadow value. In that case the
// pending flag stays set until every channel has reached its shadow value.
`timescale 1ns/1ps

module pwm_multi_gen #(
  parameter int CH      = 4,
  parameter int DW      = 12,
  parameter int CLK_DIV = 20,
  parameter int PERIOD  = 100
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             center,
  input  logic [CH*DW-1:0] duty,
  input  logic             duty_wr,
  output logic             upd_pend,
  output logic             period_start,
  output logic [CH-1:0]    pwm
);

  localparam int            PW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [DW-1:0] CNT_MAX   = DW'(PERIOD - 1);
  localparam logic [DW-1:0] CNT_ZERO  = {DW{1'b0}};

  logic [PW-1:0]    presc_q, presc_d;
  logic [DW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;      // 1 = counting down (center mode only)
  logic             mode_q, mode_d;    // latched alignment, 1 = center
  logic [CH*DW-1:0] shadow_q, shadow_d;
  logic [CH*DW-1:0] active_q, active_d;
  logic             pend_q, pend_d;
  logic             ps_q, ps_d;
  logic [CH-1:0]    pwm_q, pwm_d;

  logic [DW-1:0]    step_cnt_s;
  logic             step_dn_s;
  logic             tick_s;
  logic             wrap_s;

`ifdef PWM_RAMP_EN
  // Move every channel one LSB toward its target; channels already there stay put.
  function automatic logic [CH*DW-1:0] ramp_step(input logic [CH*DW-1:0] act,
                                                  input logic [CH*DW-1:0] shd);
    logic [CH*DW-1:0] r;
    r = act;
    for (int i = 0; i < CH; i++) begin
      if (act[i*DW +: DW] < shd[i*DW +: DW]) begin
        r[i*DW +: DW] = act[i*DW +: DW] + DW'(1);
      end else if (act[i*DW +: DW] > shd[i*DW +: DW]) begin
        r[i*DW +: DW] = act[i*DW +: DW] - DW'(1);
      end else begin
        r[i*DW +: DW] = act[i*DW +: DW];
      end
    end
    return r;
  endfunction
`endif

  // Counter value and direction that the next tick would produce.
  always_comb begin
    step_cnt_s = CNT_ZERO;
    step_dn_s  = 1'b0;
    if (mode_q) begin
      if (dir_q && (cnt_q != CNT_ZERO)) begin
        step_cnt_s = cnt_q - DW'(1);
        step_dn_s  = (step_cnt_s != CNT_ZERO);
      end else if (cnt_q >= CNT_MAX) begin
        // Turn around at the top without repeating the endpoint.
        step_cnt_s = CNT_MAX - DW'(1);
        step_dn_s  = (step_cnt_s != CNT_ZERO);
      end else begin
        step_cnt_s = cnt_q + DW'(1);
        step_dn_s  = 1'b0;
      end
    end else begin
      if (cnt_q >= CNT_MAX) begin
        step_cnt_s = CNT_ZERO;
      end else begin
        step_cnt_s = cnt_q + DW'(1);
      end
      step_dn_s = 1'b0;
    end
  end

  // Prescaler and period counter; both freeze while en is low.
  always_comb begin
    presc_d = presc_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    tick_s  = 1'b0;
    if (en && (presc_q == PRESC_MAX)) begin
      tick_s  = 1'b1;
      presc_d = PW'(0);
      cnt_d   = step_cnt_s;
      dir_d   = step_dn_s;
    end else if (en) begin
      presc_d = presc_q + PW'(1);
    end else begin
      presc_d = presc_q;
    end
  end

  assign wrap_s = tick_s && (step_cnt_s == CNT_ZERO);

  // Shadow capture and the period-start hand-over into the active set.
  // The active set takes the shadow value from before this cycle's write, so
  // a write on the wrap tick is held over to the next period start.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    mode_d   = mode_q;
    pend_d   = pend_q;
    ps_d     = wrap_s;
    if (wrap_s) begin
`ifdef PWM_RAMP_EN
      active_d = ramp_step(active_q, shadow_q);
`else
      active_d = shadow_q;
`endif
      mode_d = center;
      pend_d = (active_d != shadow_q);
    end else begin
      mode_d = mode_q;
    end
    if (duty_wr) begin
      shadow_d = duty;
      pend_d   = 1'b1;
    end else begin
      shadow_d = shadow_q;
    end
  end

  // Per-channel compare; duty >= PERIOD is always above the counter.
  always_comb begin
    pwm_d = {CH{1'b0}};
    for (int i = 0; i < CH; i++) begin
      pwm_d[i] = (active_q[i*DW +: DW] > cnt_q);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc_q  <= PW'(0);
      cnt_q    <= CNT_ZERO;
      dir_q    <= 1'b0;
      mode_q   <= 1'b0;
      shadow_q <= {(CH*DW){1'b0}};
      active_q <= {(CH*DW){1'b0}};
      pend_q   <= 1'b0;
      ps_q     <= 1'b0;
      pwm_q    <= {CH{1'b0}};
    end else begin
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      mode_q   <= mode_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      ps_q     <= ps_d;
      pwm_q    <= pwm_d;
    end
  end

  assign upd_pend     = pend_q;
  assign period_start = ps_q;
  assign pwm          = pwm_q;

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Scoreboard bench for pwm_multi_gen. A tick/phase-level reference model
// pushes the expected outputs for every clock edge into a queue. A separate
// monitor pops one entry each cycle and compares it with the DUT outputs.
`timescale 1ns/1ps

module tb_pwm_multi_gen;

  localparam int CH      = 4;
  localparam int DW      = 12;
  localparam int CLK_DIV = 2;
  localparam int PERIOD  = 100;

  logic             clk;
  logic             rstn;
  logic             en;
  logic             center;
  logic [CH*DW-1:0] duty;
  logic             duty_wr;
  logic             upd_pend;
  logic             period_start;
  logic [CH-1:0]    pwm;

  pwm_multi_gen #(.CH(CH), .DW(DW), .CLK_DIV(CLK_DIV), .PERIOD(PERIOD)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .en           (en),
    .center       (center),
    .duty         (duty),
    .duty_wr      (duty_wr),
    .upd_pend     (upd_pend),
    .period_start (period_start),
    .pwm          (pwm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CH-1:0] pwm;
    logic          pend;
    logic          ps;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: position in the period measured in ticks.
  int m_presc;
  int m_pos;
  bit m_mode;
  int m_act[CH];
  int m_shd[CH];
  bit m_pend;

  function automatic int plen();
    return m_mode ? 2 * (PERIOD - 1) : PERIOD;
  endfunction

  function automatic int m_cnt();
    if (m_mode && (m_pos > PERIOD - 1)) return plen() - m_pos;
    return m_pos;
  endfunction

  task automatic m_reset();
    m_presc = 0;
    m_pos   = 0;
    m_mode  = 1'b0;
    m_pend  = 1'b0;
    for (int i = 0; i < CH; i++) begin
      m_act[i] = 0;
      m_shd[i] = 0;
    end
  endtask

  // Reference model: one step per clock edge, expected outputs go to the queue.
  initial begin
    exp_t e;
    int   c;
    bit   wrap;
    m_reset();
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        m_reset();
      end else begin
        c = m_cnt();
        for (int i = 0; i < CH; i++) e.pwm[i] = (m_act[i] > c);
        wrap = 1'b0;
        if (en) begin
          if (m_presc == CLK_DIV - 1) begin
            m_presc = 0;
            m_pos   = m_pos + 1;
            if (m_pos == plen()) begin
              m_pos = 0;
              wrap  = 1'b1;
            end
          end else begin
            m_presc = m_presc + 1;
          end
        end
        if (wrap) begin
          m_pend = 1'b0;
          for (int i = 0; i < CH; i++) begin
`ifdef PWM_RAMP_EN
            if (m_act[i] < m_shd[i]) m_act[i] = m_act[i] + 1;
            else if (m_act[i] > m_shd[i]) m_act[i] = m_act[i] - 1;
`else
            m_act[i] = m_shd[i];
`endif
            if (m_act[i] != m_shd[i]) m_pend = 1'b1;
          end
          m_mode = center;
        end
        if (duty_wr) begin
          for (int i = 0; i < CH; i++) m_shd[i] = int'(duty[i*DW +: DW]);
          m_pend = 1'b1;
        end
        e.ps   = wrap;
        e.pend = m_pend;
        q.push_back(e);
      end
    end
  end

  // Monitor: compare on the falling edge, away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        checks++;
        if ((pwm !== {CH{1'b0}}) || (upd_pend !== 1'b0) || (period_start !== 1'b0)) begin
          errors++;
          $display("FAIL reset_outputs t=%0t pwm=%b upd_pend=%b period_start=%b required all zero",
                   $time, pwm, upd_pend, period_start);
        end
        q.delete();
      end else if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ((pwm !== e.pwm) || (upd_pend !== e.pend) || (period_start !== e.ps)) begin
          errors++;
          $display("FAIL out_check t=%0t pwm=%b exp %b upd_pend=%b exp %b period_start=%b exp %b",
                   $time, pwm, e.pwm, upd_pend, e.pend, period_start, e.ps);
        end
      end
    end
  end

  function automatic logic [CH*DW-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [CH*DW-1:0] r;
    r = {(CH*DW){1'b0}};
    r[0*DW +: DW] = DW'(a);
    r[1*DW +: DW] = DW'(b);
    r[2*DW +: DW] = DW'(c);
    r[3*DW +: DW] = DW'(d);
    return r;
  endfunction

  function automatic logic [CH*DW-1:0] rand_duty();
    logic [CH*DW-1:0] r;
    r = {(CH*DW){1'b0}};
    for (int i = 0; i < CH; i++) begin
      if ($urandom_range(0, 7) == 0) r[i*DW +: DW] = DW'(4095);
      else r[i*DW +: DW] = DW'($urandom_range(0, 110));
    end
    return r;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_duty(input logic [CH*DW-1:0] d);
    duty    = d;
    duty_wr = 1'b1;
    @(negedge clk);
    duty_wr = 1'b0;
  endtask

  // Issue a write whose strobe lands on the tick that starts the next period.
  task automatic write_at_wrap(input logic [CH*DW-1:0] d);
    int  n;
    bit  hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && (n < 5000)) begin
      @(negedge clk);
      if (en && (m_presc == CLK_DIV - 1) && (m_pos == plen() - 1)) hit = 1'b1;
      n++;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL wrap_wait waited=%0d cycles required wrap within 5000", n);
    end else begin
      write_duty(d);
    end
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #3 rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rstn = 1'b1;
  endtask

  initial begin
    rstn    = 1'b0;
    en      = 1'b0;
    center  = 1'b0;
    duty    = {(CH*DW){1'b0}};
    duty_wr = 1'b0;
    cycles(3);
    #1 rstn = 1'b1;
    en = 1'b1;

    // Edge mode, 50% duty on all channels.
    write_duty(pack4(50, 50, 50, 50));
    cycles(3 * PERIOD * CLK_DIV + 50);

    // Boundary duties: zero, exactly PERIOD, full scale.
    write_duty(pack4(0, 100, 4095, 77));
    cycles(3 * PERIOD * CLK_DIV + 50);

    // Mid-period update of channel 0.
    cycles(37);
    write_duty(pack4(25, 100, 4095, 77));
    cycles(2 * PERIOD * CLK_DIV + 100);

    // Center-aligned, duty 30.
    center = 1'b1;
    write_duty(pack4(30, 30, 30, 30));
    cycles(3 * 2 * (PERIOD - 1) * CLK_DIV + 400);

    // Write coinciding with the period-start tick.
    write_duty(pack4(60, 10, 99, 1));
    write_at_wrap(pack4(5, 6, 7, 8));
    cycles(900);

    // Back to edge mode; small step exercises the optional ramp.
    center = 1'b0;
    write_duty(pack4(0, 0, 0, 0));
    cycles(500);
    write_duty(pack4(3, 3, 3, 3));
    cycles(1000);

    // Reset mid-period with an update pending.
    write_duty(pack4(90, 45, 12, 70));
    cycles(20);
    reset_pulse();
    cycles(300);

    // Freeze while accepting a shadow write.
    en = 1'b0;
    write_duty(pack4(40, 80, 20, 60));
    cycles(50);
    en = 1'b1;
    cycles(400);

    // Randomized phase.
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: write_duty(rand_duty());
        4: begin
          en = 1'b0;
          cycles($urandom_range(1, 50));
          en = 1'b1;
        end
        5: center = 1'($urandom_range(0, 1));
        6: write_at_wrap(rand_duty());
        7: begin
          write_duty(rand_duty());
          cycles($urandom_range(1, 100));
          reset_pulse();
        end
        default: cycles(1);
      endcase
      cycles($urandom_range(20, 400));
    end

    cycles(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_multi_gen.md
PWM_MULTI_GEN -- requirements
Module: pwm_multi_gen

Interface
REQ-001 SHALL have parameter CH, default 4: number of PWM channels (1..16).
REQ-002 SHALL have parameter DW, default 12: duty/period width in bits.
REQ-003 SHALL have parameter CLK_DIV, default 20: clk cycles per count tick (>=1).
REQ-004 SHALL have parameter PERIOD, default 100: count steps per PWM period (2..2^DW-1).
REQ-005 SHALL have port clk, input, 1: system clock; all logic on rising edge, no derived clocks.
REQ-006 SHALL have port rstn, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port en, input, 1: counter run enable; low freezes prescaler and counter.
REQ-008 SHALL have port center, input, 1: 0 edge-aligned, 1 center-aligned; sampled only at period start.
REQ-009 SHALL have port duty, input, CH*DW: packed duty values, channel i in bits [i*DW +: DW].
REQ-010 SHALL have port duty_wr, input, 1: one-cycle write strobe capturing duty into shadow registers.
REQ-011 SHALL have port upd_pend, output, 1: shadow written but not yet applied.
REQ-012 SHALL have port period_start, output, 1: one-cycle pulse on the tick the counter restarts.
REQ-013 SHALL have port pwm, output, CH: registered PWM outputs.

Function
REQ-014 SHALL generate tick as a one-clk enable when prescaler == CLK_DIV-1 and en=1; prescaler wraps to 0 there.
REQ-015 Edge mode: counter SHALL count 0..PERIOD-1 on ticks, wrapping to 0.
REQ-016 Center mode: counter SHALL count up 0..PERIOD-1 then down to 0, with 2*(PERIOD-1) ticks per period and no repeated endpoint.
REQ-017 Period start SHALL be the tick where the counter becomes 0; period_start asserts the following clk cycle.
REQ-018 duty_wr SHALL load all CH shadow registers and set upd_pend=1 on the next clk edge.
REQ-019 At period start, the active duty SHALL take shadow values, the latched mode SHALL take center, and upd_pend SHALL clear.
REQ-020 duty_wr coinciding with the period-start tick: the new value SHALL be captured, applied at the next period start, and upd_pend SHALL stay 1.
REQ-021 pwm[i] SHALL equal (active_duty[i] > counter), registered, with 1 clk latency from the counter update.
REQ-022 Boundaries: duty=0 SHALL give constant 0; duty >= PERIOD SHALL give constant 1 with no glitch pulses.
REQ-023 en=0 SHALL hold counter, prescaler, and pwm at their current values; shadow writes SHALL still be accepted.
REQ-024 Compare SHALL be unsigned DW-bit with no overflow; the counter SHALL never exceed PERIOD-1.

Reset
REQ-025 rstn low SHALL asynchronously clear prescaler, counter, direction (up), shadow, active duty, and latched mode (edge).
REQ-026 During reset, pwm, upd_pend, and period_start SHALL be 0.
REQ-027 After rstn deasserts, counting SHALL start on the first clk edge with en=1.
REQ-028 Reset mid-period SHALL abandon that period; no pending update SHALL survive.

Configuration
REQ-029 Macro PWM_RAMP_EN: when defined, at each period start, active duty SHALL step toward shadow by at most 1 LSB per channel, and upd_pend SHALL clear only when all channels equal shadow.
REQ-030 Without PWM_RAMP_EN, active duty SHALL jump to shadow in one period start as in REQ-019.

Verification
REQ-031 Defaults, edge mode, duty all 50, en=1 -> pwm high for 50 of 100 ticks (1000 of 2000 clk), period_start every 2000 clk.
REQ-032 duty ch0=0, ch1=100, ch2=4095 -> ch0 constant 0; ch1 and ch2 constant 1 across 3 periods.
REQ-033 duty_wr with ch0=25 mid-period -> upd_pend=1; old duty kept until next period_start; then pwm high 25 ticks, upd_pend=0.
REQ-034 center=1, PERIOD=100, duty=30 -> period 198 ticks, pwm high on ticks with counter<30, symmetric about counter 0.
REQ-035 rstn pulse mid-period with upd_pend=1 -> pwm=0 and upd_pend=0 immediately; restart from counter 0 with duty 0.
REQ-036 With PWM_RAMP_EN, duty 0->3 -> active duty 1,2,3 over 3 successive periods; upd_pend clears at the third period start.
